// File: rtl/ym3438_op_phase.sv
// ym3438_op_phase: operator phase-modulation stage.
// Takes the phase-generator output for the current slot and adds modulation
// from earlier operator outputs of the same channel: OP1 self-feedback, or the
// algorithm-selected inter-operator terms. The modulated phase is then folded
// into a quarter-wave sine-table address plus a sign bit. Per-channel operator
// history is written back by the operator unit on c2 and read on c1.
module ym3438_op_phase (
    input  logic        MCLK,
    input  logic        IC,
    input  logic        c1,
    input  logic        c2,
    input  logic [9:0]  pg_phase,
    input  logic [2:0]  ch,
    input  logic [1:0]  op,
    input  logic [2:0]  alg,
    input  logic [2:0]  fb,
    input  logic        wb_en,
    input  logic [2:0]  wb_ch,
    input  logic [1:0]  wb_op,
    input  logic [13:0] wb_data,
    output logic [7:0]  sin_addr,
    output logic        sin_sign,
    output logic [9:0]  op_phase
);

    // A cycle with c1 and c2 both high is treated as no step at all.
    logic step_c1;
    logic step_c2;

    assign step_c1 = c1 & ~c2;
    assign step_c2 = c2 & ~c1;

    // Per-channel operator history: two most recent OP1 outputs, latest OP2 and OP3.
    logic [13:0] m1a [0:5];
    logic [13:0] m1b [0:5];
    logic [13:0] m2  [0:5];
    logic [13:0] m3  [0:5];

    logic signed [14:0] rd_m1a;
    logic signed [14:0] rd_m1b;
    logic signed [14:0] rd_m2;
    logic signed [14:0] rd_m3;

    logic signed [14:0] term_a;
    logic signed [14:0] term_b;
    logic signed [14:0] fb_sum;
    logic        [3:0]  fb_shift;
    logic signed [14:0] mod_next;

    logic [9:0]         s1_phase;
    logic signed [14:0] s1_mod;
    logic [9:0]         phase_next;

    // Fetch the current channel's history sign-extended to 15 bits; channels 6/7 read as zero.
    always_comb begin
        rd_m1a = '0;
        rd_m1b = '0;
        rd_m2  = '0;
        rd_m3  = '0;
        if (ch <= 3'd5) begin
            rd_m1a = {m1a[ch][13], m1a[ch]};
            rd_m1b = {m1b[ch][13], m1b[ch]};
            rd_m2  = {m2[ch][13],  m2[ch]};
            rd_m3  = {m3[ch][13],  m3[ch]};
        end
    end

    // Select the modulation source for this operator: feedback for OP1, algorithm routing otherwise.
    always_comb begin
        term_a   = '0;
        term_b   = '0;
        fb_sum   = rd_m1a + rd_m1b;
        fb_shift = 4'd10 - {1'b0, fb};
        mod_next = '0;
        if (op == 2'd0) begin
            if (fb != 3'd0) begin
                mod_next = fb_sum >>> fb_shift;
            end
        end else begin
            if (op == 2'd1) begin
                if (alg inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6}) begin
                    term_a = rd_m1a;
                end
            end else if (op == 2'd2) begin
                case (alg)
                    3'd0:    term_a = rd_m2;
                    3'd1:    begin term_a = rd_m1a; term_b = rd_m2; end
                    3'd2:    term_a = rd_m2;
                    3'd5:    term_a = rd_m1a;
                    default: term_a = '0;
                endcase
            end else begin
                case (alg)
                    3'd0, 3'd1, 3'd4: term_a = rd_m3;
                    3'd2:    begin term_a = rd_m1a; term_b = rd_m3; end
                    3'd3:    begin term_a = rd_m2;  term_b = rd_m3; end
                    3'd5:    term_a = rd_m1a;
                    default: term_a = '0;
                endcase
            end
            mod_next = (term_a + term_b) >>> 1;
        end
    end

    // History writeback on c2; an OP1 write shifts the previous OP1 output into M1b.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            for (int i = 0; i < 6; i++) begin
                m1a[i] <= '0;
                m1b[i] <= '0;
                m2[i]  <= '0;
                m3[i]  <= '0;
            end
        end else if (step_c2 && wb_en && (wb_ch <= 3'd5)) begin
            case (wb_op)
                2'd0: begin
                    m1b[wb_ch] <= m1a[wb_ch];
                    m1a[wb_ch] <= wb_data;
                end
                2'd1:    m2[wb_ch] <= wb_data;
                2'd2:    m3[wb_ch] <= wb_data;
                default: ;
            endcase
        end
    end

    // Stage 1: capture the slot phase and its modulation on c1.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            s1_phase <= '0;
            s1_mod   <= '0;
        end else if (step_c1) begin
            s1_phase <= pg_phase;
            s1_mod   <= mod_next;
        end
    end

    assign phase_next = 10'({5'b0, s1_phase} + s1_mod);

    // Stage 2: add, wrap to 10 bits and fold into the quarter-wave address on c2.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            op_phase <= '0;
            sin_addr <= '0;
            sin_sign <= 1'b0;
        end else if (step_c2) begin
            op_phase <= phase_next;
            sin_sign <= phase_next[9];
            sin_addr <= phase_next[8] ? ~phase_next[7:0] : phase_next[7:0];
        end
    end

endmodule

// File: doc/ym3438_op_phase.md
# ym3438_op_phase

Operator phase-modulation stage. It sits directly downstream of the phase generator and consumes its 10-bit per-slot phase output. It adds the algorithm- and feedback-dependent modulation from previously computed operator outputs, then folds the result into a quarter-wave sine-table address plus sign. It keeps a per-channel history of operator outputs, which the operator unit writes back, and runs on the shared MCLK with c1/c2 phase enables.

## Interface
Parameters:
- none; widths are fixed: phase 10 bits, operator output 14 bits signed, 6 channels.

Ports:
- MCLK  in  1  master clock; all state changes on rising edge.
- IC  in  1  asynchronous, active-low reset (initial clear).
- c1  in  1  phase-1 enable; samples slot inputs.
- c2  in  1  phase-2 enable; produces outputs and performs writeback.
- pg_phase  in  10  phase-generator output for current slot (unsigned).
- ch  in  3  channel of current slot, 0..5.
- op  in  2  operator of current slot: 0=OP1, 1=OP2, 2=OP3, 3=OP4.
- alg  in  3  channel algorithm, 0..7.
- fb  in  3  channel OP1 feedback level, 0..7.
- wb_en  in  1  write operator output back (sampled on c2).
- wb_ch  in  3  writeback channel.
- wb_op  in  2  writeback operator.
- wb_data  in  14  operator output, two's complement.
- sin_addr  out  8  quarter-wave sine-table address.
- sin_sign  out  1  1 = negative half-wave.
- op_phase  out  10  modulated phase, debug/verification.

## Operation
- Slot step: one MCLK edge with c1=1, later one with c2=1. c1 and c2 are never high together. If both are high, the block ignores both: no state change.
- History storage per channel 0..5, all 14-bit signed:
  - M1a: latest OP1 output.
  - M1b: the OP1 output before M1a.
  - M2: latest OP2 output.
  - M3: latest OP3 output.
  - OP4 output is never stored.
- Writeback on c2 with wb_en=1 and wb_ch≤5:
  - wb_op=0: M1b←M1a, then M1a←wb_data.
  - wb_op=1: M2←wb_data.
  - wb_op=2: M3←wb_data.
  - wb_op=3: ignored.
  - wb_ch 6/7: ignored.
- Reads on c1 use history as it stood before that step's c2 write. A write becomes visible at the next c1.
- Modulator terms (ch≥6 reads all zero):
  - op=0: feedback. sum = M1a+M1b, 15-bit signed. mod = fb==0 ? 0 : sum >>> (10−fb), arithmetic.
  - op=1..3: mod = (A+B) >>> 1, 15-bit signed. Absent terms are 0. A/B per alg:
  - alg0: OP2←M1, OP3←M2, OP4←M3.
  - alg1: OP2←none, OP3←M1+M2, OP4←M3.
  - alg2: OP2←none, OP3←M2, OP4←M1+M3.
  - alg3: OP2←M1, OP3←none, OP4←M2+M3.
  - alg4: OP2←M1, OP3←none, OP4←M3.
  - alg5: OP2, OP3 and OP4 each ←M1.
  - alg6: OP2←M1, OP3←none, OP4←none.
  - alg7: no modulation.
  - In all cases M1 means M1a.
- Phase: op_phase = (pg_phase + mod[9:0]) mod 1024. Two's-complement wrap; no saturation.
- Fold:
  - sin_sign = op_phase[9].
  - sin_addr = op_phase[8] ? ~op_phase[7:0] : op_phase[7:0].

## Timing
- Stage 1 (c1 edge): registers pg_phase and the 15-bit mod, computed from current inputs and history.
- Stage 2 (next c2 edge): registers op_phase, sin_addr and sin_sign from stage 1.
- Outputs for the slot sampled at c1 of step n are valid after c2 of step n and hold until c2 of step n+1.
- Latency: one slot step.
- Outputs and stage registers change only on c2 and c1 respectively. They are never combinational from inputs.
- IC low, asynchronous: all history, stage registers and outputs are cleared to 0 immediately and held while IC=0.
- First valid output: c2 of the first step whose c1 follows IC deassertion. Outputs before that stay 0.
- Reset mid-step (after c1, before c2): the stage-1 slot is discarded and its output is never produced.

## Test plan
- Reset and fold: pulse IC low, then check outputs are 0. alg=7, pg_phase=0x123 → op_phase 0x123, sin_addr 0xDC, sin_sign 0.
- Feedback: write OP1 ch0 = 100, then 200. Slot op=0, ch0, fb=7, pg 0 → mod 37, sin_addr 0x25, sign 0. With fb=0 → sin_addr 0x00.
- alg0 OP2: write OP1 ch1 = −400. Slot op=1, ch1, pg 0 → mod −200, op_phase 0x338, sin_addr 0xC7, sign 1.
- alg1 OP3: write M1a=1000, M2=600 on ch2. Slot op=2, pg 100 → op_phase 0x384, sin_addr 0x7B, sign 1.
- Wrap and extremes: alg0 OP4, M3=8191, pg 0x3FF → op_phase 0x3FE, sin_addr 0x01, sign 1.
- Write/read ordering: for ch3 OP2, the c2 write of value X in step n is not seen by c1 of step n. It is seen by c1 of step n+1.
- Write/read ordering, ignored writes: wb_ch=6 or wb_op=3 changes nothing.
- Reset between c1 and c2: the pending output is never produced, and outputs stay 0.
